// File: rtl/pll_lmmi_reconfig.sv
// pll_lmmi_reconfig: host write/read/RMW commands bridged onto the PLL_CORE LMMI port; PLL_LMMI_TIMEOUT_EN adds a wait-abort counter
module pll_lmmi_reconfig #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [6:0] cmd_offset,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_mask,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       lmmi_request,
    output logic       lmmi_wr_rdn,
    output logic [6:0] lmmi_offset,
    output logic [7:0] lmmi_wdata,
    input  logic       lmmi_ready,
    input  logic [7:0] lmmi_rdata,
    input  logic       lmmi_rdata_valid,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, REQ, RDWAIT, WREQ, RESP} state_t;
    localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_ILL = 2'b11;
    state_t     state;
    logic [1:0] op;
    logic [7:0] wdata, mask;
    logic       advance, timeout;
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end
    assign busy = state != IDLE;
    assign advance = (state == REQ || state == WREQ) ? lmmi_ready : state == RDWAIT && lmmi_rdata_valid;
`ifdef PLL_LMMI_TIMEOUT_EN
    logic [15:0] wait_cnt;
    assign timeout = (state == REQ || state == RDWAIT || state == WREQ) && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
    // zero outside the wait states and on every phase change, so each wait phase gets a fresh budget
    always_ff @(posedge clk)
        wait_cnt <= (rst || advance || state == IDLE || state == RESP) ? 16'd0 : wait_cnt + 16'd1;
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err <= 1'b0;
            lmmi_request <= 1'b0;
            lmmi_wr_rdn <= 1'b0;
            lmmi_offset <= 7'h00;
            lmmi_wdata <= 8'h00;
            op <= OP_WR;
            wdata <= 8'h00;
            mask <= 8'h00;
        end else if (timeout && !advance) begin
            state <= RESP;
            lmmi_request <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= !(cmd_valid && cmd_ready);
                    if (cmd_valid && cmd_ready) begin
                        op <= cmd_op;
                        wdata <= cmd_wdata;
                        mask <= cmd_mask;
                        lmmi_offset <= cmd_offset;
                        lmmi_wdata <= cmd_wdata;
                        lmmi_wr_rdn <= cmd_op == OP_WR;
                        lmmi_request <= cmd_op != OP_ILL;
                        rsp_valid <= cmd_op == OP_ILL;
                        rsp_err <= cmd_op == OP_ILL;
                        rsp_rdata <= 8'h00;
                        state <= cmd_op == OP_ILL ? RESP : REQ;
                    end
                end
                REQ: if (lmmi_ready) begin
                    lmmi_request <= 1'b0;
                    rsp_valid <= op == OP_WR;
                    state <= op == OP_WR ? RESP : RDWAIT;
                end
                RDWAIT: if (lmmi_rdata_valid) begin
                    rsp_rdata <= lmmi_rdata;
                    rsp_valid <= op == OP_RD;
                    lmmi_request <= op != OP_RD;
                    lmmi_wr_rdn <= op != OP_RD;
                    lmmi_wdata <= (lmmi_rdata & ~mask) | (wdata & mask);
                    state <= op == OP_RD ? RESP : WREQ;
                end
                WREQ: if (lmmi_ready) begin
                    lmmi_request <= 1'b0;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_lmmi_reconfig.sv
// tb_pll_lmmi_reconfig: directed and random commands against a register-file model of PLL_CORE with a randomized LMMI responder
module tb_pll_lmmi_reconfig;
    localparam int TO = 8;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic       lmmi_request, lmmi_wr_rdn, lmmi_ready, lmmi_rdata_valid, busy;
    logic [1:0] cmd_op;
    logic [6:0] cmd_offset, lmmi_offset;
    logic [7:0] cmd_wdata, cmd_mask, rsp_rdata, lmmi_wdata, lmmi_rdata;
    logic [7:0] mem [128];
    logic [7:0] core [128];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    pll_lmmi_reconfig #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_offset(cmd_offset),
        .cmd_wdata(cmd_wdata),
        .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .lmmi_request(lmmi_request),
        .lmmi_wr_rdn(lmmi_wr_rdn),
        .lmmi_offset(lmmi_offset),
        .lmmi_wdata(lmmi_wdata),
        .lmmi_ready(lmmi_ready),
        .lmmi_rdata(lmmi_rdata),
        .lmmi_rdata_valid(lmmi_rdata_valid),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // present one command and return just after its accept edge
    task automatic issue(input logic [1:0] op, input logic [6:0] off, input logic [7:0] wd, input logic [7:0] mk);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_offset = off;
        cmd_wdata = wd;
        cmd_mask = mk;
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_offset = 7'($urandom);
        cmd_wdata = 8'($urandom);
        cmd_mask = 8'($urandom);
    endtask

    // rw: cycles responder keeps lmmi_ready low; vw: cycles before rdata_valid; hold: cycles rsp_ready stays low
    task automatic run_cmd(input logic [1:0] op, input logic [6:0] off, input logic [7:0] wd, input logic [7:0] mk,
                           input int rw, input int vw, input int hold);
        logic [7:0] orig, merged, exp_rd;
        logic [6:0] rd_off;
        int exp_lat, exp_nreq, nreq, req_len, vcnt, hcnt, cyc;
        bit rd_pend, done, hs_prev, seen;
        orig = mem[off];
        for (int i = 0; i < 8; i++) merged[i] = mk[i] ? wd[i] : orig[i];
        exp_rd = (op == 2'b01 || op == 2'b10) ? orig : 8'h00;
        exp_lat = op == 2'b00 ? rw + 2 : op == 2'b01 ? rw + vw + 3 : op == 2'b10 ? 2 * rw + vw + 4 : 1;
        exp_nreq = op == 2'b11 ? 0 : op == 2'b10 ? 2 : 1;
        nreq = 0;
        req_len = 0;
        vcnt = 0;
        hcnt = 0;
        cyc = 0;
        rd_off = 7'h00;
        rd_pend = 0;
        done = 0;
        hs_prev = 0;
        seen = 0;
        issue(op, off, wd, mk);
        while (!done && cyc < 300) begin
            lmmi_ready = 1'($urandom) & !lmmi_request;
            lmmi_rdata = 8'($urandom);
            rsp_ready = 1'b0;
            cmd_valid = 1'($urandom);
            if (hs_prev) chk("req_gap", 32'(lmmi_request), 32'd0);
            hs_prev = 0;
            if (rd_pend) begin
                lmmi_rdata_valid = 1'b0;
                if (vcnt == 0) begin
                    lmmi_rdata_valid = 1'b1;
                    lmmi_rdata = core[rd_off];
                    rd_pend = 0;
                end else vcnt--;
            end else lmmi_rdata_valid = 1'($urandom);
            if (lmmi_request) begin
                if (req_len == rw) begin
                    nreq++;
                    chk("req_offset", 32'(lmmi_offset), 32'(off));
                    chk("req_wr_rdn", 32'(lmmi_wr_rdn), 32'(nreq == 2 || op == 2'b00));
                    if (lmmi_wr_rdn) begin
                        chk("req_wdata", 32'(lmmi_wdata), 32'(op == 2'b00 ? wd : merged));
                        core[lmmi_offset] = lmmi_wdata;
                    end else begin
                        rd_pend = 1;
                        vcnt = vw;
                        rd_off = lmmi_offset;
                    end
                    lmmi_ready = 1'b1;
                    hs_prev = 1;
                    req_len = 0;
                end else req_len++;
            end else if (req_len > 0) begin
                chk("req_held", 32'(lmmi_request), 32'd1);
                req_len = 0;
            end
            if (rsp_valid) begin
                if (!seen) begin
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
                    chk("rsp_err", 32'(rsp_err), 32'(op == 2'b11));
                    chk("rsp_latency", cyc + 1, exp_lat);
                    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                end else begin
                    chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(exp_rd));
                    chk("rsp_err_hold", 32'(rsp_err), 32'(op == 2'b11));
                end
                seen = 1;
                if (hcnt == hold) begin
                    rsp_ready = 1'b1;
                    done = 1;
                end else hcnt++;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        lmmi_ready = 1'b0;
        lmmi_rdata_valid = 1'b0;
        if (!done) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("cmd_ready_done", 32'(cmd_ready), 32'd1);
        chk("nreq", nreq, exp_nreq);
        if (op == 2'b00) mem[off] = wd;
        else if (op == 2'b10) mem[off] = merged;
        chk("core_reg", 32'(core[off]), 32'(mem[off]));
    endtask

    initial begin
        int high;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_offset = 7'h00;
        cmd_wdata = 8'h00;
        cmd_mask = 8'h00;
        rsp_ready = 1'b0;
        lmmi_ready = 1'b0;
        lmmi_rdata = 8'h00;
        lmmi_rdata_valid = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'($urandom);
            core[i] = mem[i];
        end
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_lmmi_request", 32'(lmmi_request), 32'd0);
        chk("rst_lmmi_wr_rdn", 32'(lmmi_wr_rdn), 32'd0);
        chk("rst_lmmi_offset", 32'(lmmi_offset), 32'd0);
        chk("rst_lmmi_wdata", 32'(lmmi_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        mem[7'h05] = 8'h3C;
        core[7'h05] = 8'h3C;
        mem[7'h20] = 8'hF0;
        core[7'h20] = 8'hF0;
        run_cmd(2'b00, 7'h12, 8'hA5, 8'h00, 0, 0, 0);
        chk("write_result", 32'(core[7'h12]), 32'h0000_00A5);
        run_cmd(2'b01, 7'h05, 8'h00, 8'h00, 3, 2, 0);
        run_cmd(2'b10, 7'h20, 8'h05, 8'h0F, 0, 0, 0);
        chk("rmw_result", 32'(core[7'h20]), 32'h0000_00F5);
        run_cmd(2'b11, 7'h44, 8'h99, 8'hFF, 0, 0, 5);
        run_cmd(2'b01, 7'h12, 8'h00, 8'h00, 0, 0, 1);
        run_cmd(2'b10, 7'h05, 8'hFF, 8'hC3, 2, 1, 2);
        issue(2'b00, 7'h33, 8'h5A, 8'h00);
        high = 0;
        for (int i = 0; i < 130 && !rsp_valid; i++) begin
            if (lmmi_request) high++;
            tick();
        end
`ifdef PLL_LMMI_TIMEOUT_EN
        chk("timeout_len", high, TO);
        chk("timeout_req", 32'(lmmi_request), 32'd0);
        chk("timeout_err", 32'(rsp_err), 32'd1);
        chk("timeout_rdata", 32'(rsp_rdata), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("timeout_idle", 32'(busy), 32'd0);
`else
        chk("stuck_len", high, 130);
        chk("stuck_req", 32'(lmmi_request), 32'd1);
        chk("stuck_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stuck_rst_req", 32'(lmmi_request), 32'd0);
        chk("stuck_rst_busy", 32'(busy), 32'd0);
`endif
        chk("stuck_core", 32'(core[7'h33]), 32'(mem[7'h33]));
        issue(2'b01, 7'h20, 8'h00, 8'h00);
        lmmi_ready = 1'b1;
        tick();
        lmmi_ready = 1'b0;
        chk("rdwait_req_low", 32'(lmmi_request), 32'd0);
        chk("rdwait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(lmmi_request), 32'd0);
        chk("midrst_rsp", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        lmmi_rdata_valid = 1'b1;
        lmmi_rdata = 8'hEE;
        repeat (3) begin
            tick();
            chk("late_valid_rsp", 32'(rsp_valid), 32'd0);
            chk("late_valid_busy", 32'(busy), 32'd0);
        end
        lmmi_rdata_valid = 1'b0;
        run_cmd(2'b01, 7'h20, 8'h00, 8'h00, 1, 0, 0);
        for (int k = 0; k < 60; k++)
            run_cmd(2'($urandom), 7'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
